sw_event_gen: RTL and testbench
===============================

SW_EVENT_GEN -- requirements
Module: sw_event_gen

Interface
REQ-001 SHALL have parameter P_SIM, default 0, meaning 1 = simulation tick of 2 CLK cycles.
REQ-002 SHALL have parameter P_DBUS_W, default 8, meaning number of debounced switch inputs (1..16).
REQ-003 SHALL have parameter P_ACT_LVL, default 1'b1, meaning SW_I level that denotes "pressed".
REQ-004 SHALL have parameter P_TICK_CNT, default 100000, meaning CLK cycles per hold tick (1 ms at 100 MHz).
REQ-005 SHALL have parameter P_LONG_TICKS, default 8'd200, meaning ticks held before a LONG event (1..255).
REQ-006 SHALL have parameter P_RPT_TICKS, default 8'd50, meaning ticks between REPEAT events (0 = repeat disabled).
REQ-007 SHALL have parameter P_FIFO_AW, default 2, meaning log2 of event FIFO depth.
REQ-008 SHALL have CLK, input, 1, the single clock; all logic runs on its rising edge.
REQ-009 SHALL have RST_N, input, 1, asynchronous active-low reset.
REQ-010 SHALL have SW_I, input, P_DBUS_W, the debounced switch levels from the switch filter.
REQ-011 SHALL have EVT_VALID, output, 1, asserted when an event is presented.
REQ-012 SHALL have EVT_READY, input, 1, asserted when the consumer accepts the event.
REQ-013 SHALL have EVT_CODE, output, 2, 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
REQ-014 SHALL have EVT_IDX, output, 4, the switch index of the presented event.
REQ-015 SHALL have EVT_OVF, output, 1, a sticky flag set when an event is lost.
REQ-016 SHALL have OVF_CLR, input, 1, a one-cycle pulse that clears EVT_OVF.

Function
REQ-017 SHALL generate a tick pulse of one cycle every P_TICK_CNT cycles (every 2 cycles when P_SIM = 1), using a free-running 17-bit counter.
REQ-018 SHALL capture SW_I into r_prev in the first cycle after reset and SHALL emit no event for that cycle (arm cycle), so a switch held at reset produces no PRESS event.
REQ-019 SHALL run one FSM per switch with states IDLE, PRESSED and HELD.
REQ-020 In IDLE, an inactive-to-active edge SHALL produce a PRESS event, clear the hold counter and enter PRESSED.
REQ-021 In PRESSED, each tick SHALL increment the 8-bit hold counter; when the counter equals P_LONG_TICKS, the FSM SHALL produce a LONG event, clear the counter and enter HELD.
REQ-022 In HELD, with P_RPT_TICKS nonzero, the counter SHALL produce a REPEAT event and clear itself when it equals P_RPT_TICKS; with P_RPT_TICKS = 0, the counter SHALL saturate at 255 and produce no events.
REQ-023 In PRESSED or HELD, an active-to-inactive edge SHALL produce a RELEASE event and return the FSM to IDLE; this SHALL take precedence over a tick in the same cycle.
REQ-024 Each produced event SHALL set a per-switch, per-code pending bit, giving 4 x P_DBUS_W bits.
REQ-025 If a pending bit is already set when the same event occurs again, the bit SHALL stay set and EVT_OVF SHALL set.
REQ-026 The scanner SHALL, each cycle the FIFO is not full, push exactly one pending event into the FIFO and clear its pending bit.
REQ-027 Scanner priority SHALL be lowest switch index first, then lowest code first.
REQ-028 The FIFO SHALL hold 2^P_FIFO_AW entries of {code, idx}.
REQ-029 EVT_VALID SHALL equal not-empty, with EVT_CODE and EVT_IDX taken from the head entry.
REQ-030 A pop SHALL occur when EVT_VALID and EVT_READY are both 1; head data SHALL stay stable while EVT_VALID = 1 and EVT_READY = 0.
REQ-031 A simultaneous push and pop on a full FIFO SHALL be allowed; the pointers SHALL wrap modulo depth.
REQ-032 Latency: a SW_I edge in cycle n with an empty FIFO and no other pending events SHALL assert EVT_VALID in cycle n+2.
REQ-033 If OVF_CLR is asserted in the same cycle as a new overflow, the set SHALL take precedence.
REQ-034 For P_DBUS_W < 16, EVT_IDX upper bits SHALL be 0.

Reset
REQ-035 RST_N = 0 SHALL asynchronously force EVT_VALID = 0, EVT_CODE = 0, EVT_IDX = 0 and EVT_OVF = 0, and SHALL clear all FSMs to IDLE, all counters, pending bits and FIFO pointers, and the arm flag.
REQ-036 Reset asserted mid-operation SHALL discard all queued and pending events; the first cycle after release SHALL be an arm cycle.

Structure
REQ-037 Package sw_pkg SHALL hold the event codes (EVT_PRESS, EVT_RELEASE, EVT_LONG, EVT_REPEAT), the FSM state encodings, and the 4-bit index width constant.
REQ-038 The FIFO SHALL be a sub-module named sw_evt_fifo with parameters for address width and data width, and the same CLK/RST_N.

Verification (P_SIM = 1, P_DBUS_W = 4, P_LONG_TICKS = 3, P_RPT_TICKS = 2, P_FIFO_AW = 2)
REQ-039 Scenario 1: SW_I[2] rises with EVT_READY = 1 -> {PRESS, 2} appears 2 cycles later for 1 cycle; SW_I[2] falls -> {RELEASE, 2}.
REQ-040 Scenario 2: SW_I[0] is held for 14 cycles -> the sequence PRESS, LONG after 3 ticks, then REPEAT every 2 ticks, then RELEASE on the falling edge.
REQ-041 Scenario 3: SW_I[3] and SW_I[1] rise in the same cycle -> {PRESS, 1} is presented before {PRESS, 3}.
REQ-042 Scenario 4: EVT_READY = 0 while 6 edges occur on SW_I[0] -> 4 events are queued, EVT_OVF = 1, EVT_VALID and head data are stable, and EVT_OVF returns to 0 after an OVF_CLR pulse.
REQ-043 Scenario 5: SW_I = 4'hF during reset -> after release, no PRESS events; the first event is RELEASE after SW_I falls.
REQ-044 Scenario 6: RST_N is pulsed low with 3 events queued -> EVT_VALID = 0 immediately, and no stale events appear after release.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: event codes, per-switch FSM states and shared widths for sw_event_gen.
package sw_pkg;
    localparam int IDX_W = 4;
    localparam int CODE_W = 2;
    localparam int EVT_W = CODE_W + IDX_W;
    typedef enum logic [CODE_W-1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } sw_state_t;
endpackage

// File: rtl/sw_evt_fifo.sv
// sw_evt_fifo: small synchronous event FIFO; head data reads as zero while empty.
module sw_evt_fifo #(
    parameter int P_AW = 2,
    parameter int P_DW = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            push,
    input  logic [P_DW-1:0] din,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [P_DW-1:0] dout
);
    logic [P_DW-1:0] mem [2**P_AW];
    logic [P_AW:0] wp, rp;
    logic wr, rd;
    assign empty = wp == rp;
    assign full = (wp[P_AW] != rp[P_AW]) && (wp[P_AW-1:0] == rp[P_AW-1:0]);
    assign rd = pop && !empty;
    // a pop frees the slot the same cycle, so a full FIFO may still accept a write
    assign wr = push && (!full || rd);
    assign dout = empty ? '0 : mem[rp[P_AW-1:0]];
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + (P_AW+1)'(1);
            if (rd) rp <= rp + (P_AW+1)'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (wr) mem[wp[P_AW-1:0]] <= din;
    end
endmodule

// File: rtl/sw_event_gen.sv
// sw_event_gen: turns debounced switch levels into PRESS/RELEASE/LONG/REPEAT events
// queued through per-switch pending bits and a small FIFO.
module sw_event_gen
    import sw_pkg::*;
#(
    parameter int         P_SIM        = 0,
    parameter int         P_DBUS_W     = 8,
    parameter logic       P_ACT_LVL    = 1'b1,
    parameter int         P_TICK_CNT   = 100000,
    parameter logic [7:0] P_LONG_TICKS = 8'd200,
    parameter logic [7:0] P_RPT_TICKS  = 8'd50,
    parameter int         P_FIFO_AW    = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [P_DBUS_W-1:0] SW_I,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [CODE_W-1:0]   EVT_CODE,
    output logic [IDX_W-1:0]    EVT_IDX,
    output logic                EVT_OVF,
    input  logic                OVF_CLR
);
    localparam int TICK_LIM = (P_SIM != 0) ? 2 : P_TICK_CNT;
    localparam int NPEND = 4 * P_DBUS_W;

    logic [16:0] tick_cnt;
    logic tick;
    assign tick = tick_cnt == 17'(TICK_LIM - 1);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 17'd1;
    end

    logic armed;
    logic [P_DBUS_W-1:0] r_prev, act, prv, rise, fall;
    assign act = SW_I ^ {P_DBUS_W{~P_ACT_LVL}};
    assign prv = r_prev ^ {P_DBUS_W{~P_ACT_LVL}};
    assign rise = act & ~prv & {P_DBUS_W{armed}};
    assign fall = ~act & prv & {P_DBUS_W{armed}};
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed <= 1'b0;
            r_prev <= '0;
        end else begin
            armed <= 1'b1;
            r_prev <= SW_I;
        end
    end

    // ev/pend bit 4*i+c holds event code c of switch i
    logic [NPEND-1:0] ev, pend, clr;
    for (genvar g = 0; g < P_DBUS_W; g++) begin : g_sw
        sw_state_t st;
        logic [7:0] cnt;
        logic prs, rls, lng, rpt;
        assign prs = st == ST_IDLE && rise[g];
        assign rls = st != ST_IDLE && fall[g];
        assign lng = st == ST_PRESSED && tick && !fall[g] && cnt + 8'd1 == P_LONG_TICKS;
        assign rpt = st == ST_HELD && tick && !fall[g] && P_RPT_TICKS != 8'd0 && cnt + 8'd1 == P_RPT_TICKS;
        assign ev[4*g +: 4] = {rpt, lng, rls, prs};
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                st <= ST_IDLE;
                cnt <= '0;
            end else if (!armed) begin
                // a switch already down at arm time is tracked as pressed so its release still reports
                st <= act[g] ? ST_PRESSED : ST_IDLE;
                cnt <= '0;
            end else if (prs || rls) begin
                st <= prs ? ST_PRESSED : ST_IDLE;
                cnt <= '0;
            end else if (tick && st == ST_PRESSED) begin
                st <= lng ? ST_HELD : ST_PRESSED;
                cnt <= lng ? '0 : cnt + 8'd1;
            end else if (tick && st == ST_HELD) begin
                cnt <= rpt ? '0 : cnt + {7'd0, cnt != 8'hFF};
            end
        end
    end

    logic [IDX_W+1:0] sel;
    logic push, full, empty;
    logic [EVT_W-1:0] head;
    always_comb begin
        sel = '0;
        for (int k = NPEND - 1; k >= 0; k--) if (pend[k]) sel = (IDX_W+2)'(k);
    end
    assign push = |pend && !full;
    assign clr = push ? NPEND'(1) << sel : '0;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend <= '0;
            EVT_OVF <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | ev;
            EVT_OVF <= (EVT_OVF && !OVF_CLR) || |(ev & pend);
        end
    end

    sw_evt_fifo #(.P_AW(P_FIFO_AW), .P_DW(EVT_W)) u_fifo (
        .CLK  (CLK),
        .RST_N(RST_N),
        .push (push),
        .din  ({sel[1:0], sel[IDX_W+1:2]}),
        .pop  (EVT_READY),
        .full (full),
        .empty(empty),
        .dout (head)
    );
    assign EVT_VALID = !empty;
    assign {EVT_CODE, EVT_IDX} = head;
endmodule

// File: tb/tb_sw_event_gen.sv
// tb_sw_event_gen: scenario and randomized checks of sw_event_gen against a reference model
// that counts held ticks per switch and keeps events in plain arrays and a queue.
module tb_sw_event_gen;
    localparam int W = 4, LONG = 3, RPT = 2, DEPTH = 4;
    logic CLK = 1'b0, RST_N = 1'b0, EVT_READY = 1'b0, OVF_CLR = 1'b0;
    logic [W-1:0] SW_I = '0;
    logic EVT_VALID, EVT_OVF;
    logic [1:0] EVT_CODE;
    logic [3:0] EVT_IDX;
    int checks = 0, failures = 0;

    bit m_down [W];
    int m_ticks [W];
    bit [3:0] m_pend [W];
    logic [5:0] m_q [$];
    bit m_ovf, m_armed;
    int m_cyc;

    sw_event_gen #(.P_SIM(1), .P_DBUS_W(W), .P_ACT_LVL(1'b1), .P_TICK_CNT(100000),
                   .P_LONG_TICKS(8'(LONG)), .P_RPT_TICKS(8'(RPT)), .P_FIFO_AW(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .SW_I(SW_I), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
        .EVT_CODE(EVT_CODE), .EVT_IDX(EVT_IDX), .EVT_OVF(EVT_OVF), .OVF_CLR(OVF_CLR)
    );

    always #5 CLK = ~CLK;

    function automatic bit m_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic [5:0] m_head();
        return m_q.size() > 0 ? m_q[0] : 6'h0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < W; i++) begin
            m_down[i] = 0;
            m_ticks[i] = 0;
            m_pend[i] = '0;
        end
        m_q.delete();
        m_ovf = 0;
        m_armed = 0;
        m_cyc = 0;
    endfunction

    // one clock edge: events come from level changes and from the number of ticks a switch
    // has been held since its press (LONG at LONG ticks, REPEAT every RPT ticks after that)
    function automatic void model_edge(input logic [W-1:0] sw, input logic rdy, input logic clr);
        bit [3:0] ev [W];
        bit tick, set, found, pop;
        int si, sc;
        tick = (m_cyc % 2) == 1;
        pop = m_q.size() > 0 && rdy;
        found = 0; si = 0; sc = 0; set = 0;
        if (m_q.size() < DEPTH)
            for (int i = 0; i < W; i++)
                for (int c = 0; c < 4; c++)
                    if (!found && m_pend[i][c]) begin found = 1; si = i; sc = c; end
        for (int i = 0; i < W; i++) begin
            ev[i] = '0;
            if (!m_armed) begin
                m_down[i] = sw[i];
                m_ticks[i] = 0;
            end else if (sw[i] && !m_down[i]) begin
                ev[i][0] = 1; m_down[i] = 1; m_ticks[i] = 0;
            end else if (!sw[i] && m_down[i]) begin
                ev[i][1] = 1; m_down[i] = 0;
            end else if (m_down[i] && tick) begin
                m_ticks[i]++;
                ev[i][2] = m_ticks[i] == LONG;
                ev[i][3] = m_ticks[i] > LONG && (m_ticks[i] - LONG) % RPT == 0;
            end
            if ((ev[i] & m_pend[i]) != 0) set = 1;
        end
        if (found) m_pend[si][sc] = 0;
        for (int i = 0; i < W; i++) m_pend[i] = m_pend[i] | ev[i];
        if (pop) void'(m_q.pop_front());
        if (found) m_q.push_back({sc[1:0], si[3:0]});
        m_ovf = (m_ovf && !clr) || set;
        m_armed = 1;
        m_cyc++;
    endfunction

    task automatic step(input logic [W-1:0] sw, input logic rdy, input logic clr);
        SW_I = sw; EVT_READY = rdy; OVF_CLR = clr;
        model_edge(sw, rdy, clr);
        @(posedge CLK);
        #1;
    endtask

    task automatic release_reset(input logic [W-1:0] sw);
        SW_I = sw; EVT_READY = 1'b0; OVF_CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        checks++;
        if ({EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b ovf=%b code=%0d idx=%0d, expected all zero", EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX);
        end
        release_reset('0);
        for (int k = 0; k < 4; k++) begin
            step('0, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== 1'b0 || EVT_OVF !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: got v=%b ovf=%b, expected 0 0", EVT_VALID, EVT_OVF);
            end
        end
    endtask

    task automatic test_press();
        step(4'b0100, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL press_early: got v=%b, expected 0", EVT_VALID); end
        step(4'b0100, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== 6'h02) begin
            failures++;
            $display("FAIL press_head: got v=%b code=%0d idx=%0d, expected v=1 code=0 idx=2", EVT_VALID, EVT_CODE, EVT_IDX);
        end
        step(4'b0100, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL press_one_cycle: got v=%b, expected 0", EVT_VALID); end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== 6'h12) begin
            failures++;
            $display("FAIL release_head: got v=%b code=%0d idx=%0d, expected v=1 code=1 idx=2", EVT_VALID, EVT_CODE, EVT_IDX);
        end
        step(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_long_repeat();
        logic [1:0] codes [$];
        int n_rpt = 0;
        bit ok;
        for (int k = 0; k < 24; k++) begin
            step(k < 14 ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL long_model: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h at %0t",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head(), $time);
            end
            if (EVT_VALID === 1'b1) codes.push_back(EVT_CODE);
        end
        ok = codes.size() >= 4 && codes[0] == 2'd0 && codes[1] == 2'd2 && codes[codes.size()-1] == 2'd1;
        for (int k = 2; k < codes.size() - 1; k++) if (codes[k] == 2'd3) n_rpt++; else ok = 0;
        checks++;
        if (!ok || n_rpt < 1 || n_rpt > 2) begin
            failures++;
            $display("FAIL long_sequence: got %0d events with %0d repeats, expected PRESS LONG REPEAT(1..2) RELEASE", codes.size(), n_rpt);
        end
    endtask

    task automatic test_simultaneous();
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== 6'h01) begin
            failures++;
            $display("FAIL simul_first: got v=%b code=%0d idx=%0d, expected v=1 code=0 idx=1", EVT_VALID, EVT_CODE, EVT_IDX);
        end
        step(4'b1010, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== 6'h03) begin
            failures++;
            $display("FAIL simul_second: got v=%b code=%0d idx=%0d, expected v=1 code=0 idx=3", EVT_VALID, EVT_CODE, EVT_IDX);
        end
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL simul_model: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head());
            end
        end
    endtask

    task automatic test_overflow();
        logic [5:0] head0 = '0;
        bit stable = 1;
        for (int k = 0; k < 48; k++) begin
            step(((k / 8) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL ovf_model: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head());
            end
            if (k == 1) head0 = {EVT_CODE, EVT_IDX};
            if (k >= 1 && (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== head0)) stable = 0;
        end
        checks++;
        if (!stable || head0 !== 6'h00) begin
            failures++;
            $display("FAIL ovf_stable: got stable=%b head=%h, expected stable=1 head=00", stable, head0);
        end
        checks++;
        if (EVT_OVF !== 1'b1) begin failures++; $display("FAIL ovf_set: got ovf=%b, expected 1", EVT_OVF); end
        step(4'b0000, 1'b0, 1'b1);
        checks++;
        if (EVT_OVF !== 1'b0 || EVT_VALID !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: got ovf=%b v=%b, expected ovf=0 v=1", EVT_OVF, EVT_VALID);
        end
        for (int k = 0; k < 16; k++) begin
            step(4'b0000, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL ovf_drain: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head());
            end
        end
    endtask

    task automatic test_held_reset();
        RST_N = 1'b0;
        SW_I = 4'hF;
        #1;
        release_reset(4'hF);
        for (int k = 0; k < 4; k++) begin
            step(4'hF, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL held_no_press: got v=%b code=%0d, expected v=0", EVT_VALID, EVT_CODE); end
        end
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || {EVT_CODE, EVT_IDX} !== 6'h10) begin
            failures++;
            $display("FAIL held_first_release: got v=%b code=%0d idx=%0d, expected v=1 code=1 idx=0", EVT_VALID, EVT_CODE, EVT_IDX);
        end
        for (int k = 0; k < 8; k++) begin
            step(4'h0, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL held_model: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head());
            end
        end
    endtask

    task automatic test_reset_midflight();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        checks++;
        if (EVT_VALID !== 1'b1 || m_q.size() != 3) begin
            failures++;
            $display("FAIL mid_queued: got v=%b with model depth %0d, expected v=1 depth 3", EVT_VALID, m_q.size());
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX} !== 8'h00) begin
            failures++;
            $display("FAIL mid_async: got v=%b ovf=%b code=%0d idx=%0d, expected all zero", EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX);
        end
        release_reset('0);
        for (int k = 0; k < 10; k++) begin
            step('0, 1'b1, 1'b0);
            checks++;
            if (EVT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_stale: got v=%b code=%0d idx=%0d, expected v=0", EVT_VALID, EVT_CODE, EVT_IDX);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] sw = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 9) == 0) sw[i] = ~sw[i];
            step(sw, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            checks++;
            if (EVT_VALID !== m_valid() || EVT_OVF !== m_ovf || (m_valid() && {EVT_CODE, EVT_IDX} !== m_head())) begin
                failures++;
                $display("FAIL rand_model: got v=%b ovf=%b code=%0d idx=%0d, expected v=%b ovf=%b head=%h at %0t",
                         EVT_VALID, EVT_OVF, EVT_CODE, EVT_IDX, m_valid(), m_ovf, m_head(), $time);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_long_repeat();
        test_simultaneous();
        test_overflow();
        test_held_reset();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
